avalon_wait_ram: RTL and testbench

Parametrised single-port Avalon-MM slave RAM for the MIPS CPU test environment. It replaces the fixed zero-wait bench RAM with one that has configurable depth and base address. Wait states are either fixed or pseudo-random, and byte enables are honoured. It also provides a clocked preload port and a sticky protocol-error flag. It sits between `top_level_cpu`'s Avalon master and the bench.

---
 rtl/avalon_wait_ram_pkg.sv | 24 ++
 rtl/avalon_wait_ram_if.sv | 20 ++
 rtl/avalon_wait_ram_lfsr8.sv | 24 ++
 rtl/avalon_wait_ram.sv | 106 ++++++++++
 tb/tb_avalon_wait_ram.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_wait_ram_pkg.sv
// Shared types and helpers for the wait-state Avalon RAM.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } ram_state_t;

  // Fibonacci taps 8,6,5,4 expressed as state-bit mask 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM bus bundle between the CPU master and the RAM slave.
interface avalon_wait_ram_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );
endinterface

// File: rtl/avalon_wait_ram_lfsr8.sv
// 8-bit Fibonacci LFSR, advances one step per enabled cycle.
module lfsr8
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [7:0] i_seed,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= {r_state[6:0], ^(r_state & LFSR_TAPS)};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with fixed or pseudo-random wait states, byte enables,
// a clocked preload port and a sticky protocol-error flag.
module avalon_wait_ram
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned WAIT_MODE  = 0,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 1,
  parameter int unsigned MAX_WAIT   = 3,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_wait_ram_if.slave      bus,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  prot_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [DEPTH];
  ram_state_t  r_state;
  logic [3:0]  r_cnt;
  logic        r_prot_err;

  logic                  w_req;
  logic                  w_in_range;
  logic                  w_err;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_wr_commit;
  logic [31:0]           w_off;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [3:0]            w_lat;
  logic [7:0]            w_lfsr;

  always_comb begin
    w_req      = bus.read | bus.write;
    w_off      = bus.address - BASE_ADDR;
    w_word     = w_off[ADDR_WIDTH+1:2];
    w_in_range = (bus.address >= BASE_ADDR) && (bus.address[1:0] == 2'b00) &&
                 ((w_off >> (ADDR_WIDTH + 2)) == '0);
    w_err      = !w_in_range || (bus.read && bus.write);
    if (WAIT_MODE == 0) w_lat = bus.write ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
    else                w_lat = 4'(32'(w_lfsr) % (MAX_WAIT + 1));
    w_accept    = (r_state == IDLE) && w_req;
    w_complete  = (w_accept && (w_lat == '0)) || ((r_state == DONE) && w_req);
    w_wr_commit = reset && w_complete && bus.write && w_in_range;
  end

  assign bus.waitrequest = reset && ((w_accept && (w_lat != '0)) || (r_state == WAIT));
  assign bus.readdata    = (reset && w_complete && bus.read && !bus.write && w_in_range)
                           ? r_mem[w_word] : '0;
  assign prot_err        = r_prot_err;

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_accept),
    .i_seed  (SEED),
    .o_state (w_lfsr)
  );

  // The move to DONE happens on the edge where the count lands on zero, so a
  // latency of L keeps waitrequest high for exactly L cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_prot_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && (w_lat != '0)) begin
            r_cnt   <= w_lat - 4'd1;
            r_state <= (w_lat == 4'd1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!w_req) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_prot_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_complete && w_err) r_prot_err <= 1'b1;
    end
  end

  // Preload is written last so it overrides a bus write to the same word.
  always_ff @(posedge clk) begin
    if (w_wr_commit) r_mem[w_word] <= byte_merge(r_mem[w_word], bus.writedata, bus.byteenable);
    if (load_en)     r_mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Directed and randomized checks of avalon_wait_ram against a behavioural model.
module tb_avalon_wait_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  int          sel;
  logic [31:0] t_addr, t_wdata, t_ldata;
  logic        t_rd, t_wr, t_load;
  logic [3:0]  t_be;
  logic [9:0]  t_laddr;
  logic        pe0, pe1, pe2;
  logic        w_wait, w_perr;
  logic [31:0] w_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_mem [3][1024];
  logic        m_perr [3];
  logic [7:0]  m_lfsr;
  int unsigned addrs [50];

  always #5 clk = ~clk;

  avalon_wait_ram_if bus0 ();
  avalon_wait_ram_if bus1 ();
  avalon_wait_ram_if bus2 ();

  assign bus0.address = t_addr; assign bus0.writedata = t_wdata; assign bus0.byteenable = t_be;
  assign bus1.address = t_addr; assign bus1.writedata = t_wdata; assign bus1.byteenable = t_be;
  assign bus2.address = t_addr; assign bus2.writedata = t_wdata; assign bus2.byteenable = t_be;
  assign bus0.read = t_rd && (sel == 0); assign bus0.write = t_wr && (sel == 0);
  assign bus1.read = t_rd && (sel == 1); assign bus1.write = t_wr && (sel == 1);
  assign bus2.read = t_rd && (sel == 2); assign bus2.write = t_wr && (sel == 2);

  // sel 0: fixed 2/1 waits; sel 1: zero wait, 16 words at 0x1000; sel 2: random waits
  avalon_wait_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_MODE(0),
                    .READ_WAIT(2), .WRITE_WAIT(1)) u_fix (
    .clk(clk), .reset(rst_n), .bus(bus0), .load_en(t_load && (sel == 0)),
    .load_addr(t_laddr), .load_data(t_ldata), .prot_err(pe0));

  avalon_wait_ram #(.ADDR_WIDTH(4), .BASE_ADDR(32'h1000), .WAIT_MODE(0),
                    .READ_WAIT(0), .WRITE_WAIT(0)) u_zero (
    .clk(clk), .reset(rst_n), .bus(bus1), .load_en(t_load && (sel == 1)),
    .load_addr(t_laddr[3:0]), .load_data(t_ldata), .prot_err(pe1));

  avalon_wait_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_MODE(1),
                    .MAX_WAIT(3), .SEED(8'hA5)) u_rnd (
    .clk(clk), .reset(rst_n), .bus(bus2), .load_en(t_load && (sel == 2)),
    .load_addr(t_laddr), .load_data(t_ldata), .prot_err(pe2));

  always_comb begin
    w_wait  = bus0.waitrequest;
    w_rdata = bus0.readdata;
    w_perr  = pe0;
    if (sel == 1) begin
      w_wait = bus1.waitrequest; w_rdata = bus1.readdata; w_perr = pe1;
    end else if (sel == 2) begin
      w_wait = bus2.waitrequest; w_rdata = bus2.readdata; w_perr = pe2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic bit mapped(input int s, input logic [31:0] a, output int unsigned idx);
    logic [31:0] base;
    logic [31:0] off;
    int unsigned depth;
    base  = (s == 1) ? 32'h1000 : 32'h0;
    depth = (s == 1) ? 16 : 1024;
    off   = a - base;
    idx   = off / 4;
    return (a >= base) && (a % 4 == 0) && (idx < depth);
  endfunction

  task automatic do_reset();
    t_rd = 1'b0; t_wr = 1'b0; t_load = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_perr0", {31'b0, pe0}, 32'h0);
    check("rst_perr1", {31'b0, pe1}, 32'h0);
    check("rst_perr2", {31'b0, pe2}, 32'h0);
    m_perr = '{1'b0, 1'b0, 1'b0};
    m_lfsr = 8'hA5;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic preload(input int s, input int unsigned w, input logic [31:0] d);
    sel = s; t_load = 1'b1; t_laddr = 10'(w); t_ldata = d;
    @(posedge clk); #1;
    t_load = 1'b0;
    m_mem[s][w] = d;
  endtask

  task automatic transact(input int s, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input string tag);
    int unsigned idx;
    int          exp_stall, stall;
    bit          ok;
    logic [31:0] exp_rd, rdata;
    ok = mapped(s, addr, idx);
    if (s == 0)      exp_stall = wr ? 1 : 2;
    else if (s == 1) exp_stall = 0;
    else begin
      exp_stall = int'(m_lfsr) % 4;
      m_lfsr = lfsr_next(m_lfsr);
    end
    exp_rd = (rd && !wr && ok) ? m_mem[s][idx] : 32'h0;
    if (wr && ok)
      for (int b = 0; b < 4; b++) if (be[b]) m_mem[s][idx][8*b +: 8] = data[8*b +: 8];
    if (!ok || (rd && wr)) m_perr[s] = 1'b1;

    sel = s; t_addr = addr; t_rd = rd; t_wr = wr; t_wdata = data; t_be = be;
    stall = 0;
    @(negedge clk);
    while (w_wait !== 1'b0 && stall < 20) begin
      stall++;
      @(negedge clk);
    end
    rdata = w_rdata;
    @(posedge clk); #1;
    t_rd = 1'b0; t_wr = 1'b0;
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_perr"}, {31'b0, w_perr}, {31'b0, m_perr[s]});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; t_addr = '0; t_wdata = '0; t_ldata = '0; t_rd = 0; t_wr = 0;
    t_load = 0; t_be = '0; t_laddr = '0; rst_n = 1'b1;
    m_lfsr = 8'hA5;
    m_perr = '{1'b0, 1'b0, 1'b0};
    for (int s = 0; s < 3; s++) for (int w = 0; w < 1024; w++) m_mem[s][w] = '0;

    // outputs held quiet under reset even with a request pending
    #1 rst_n = 1'b0;
    t_rd = 1'b1; t_addr = 32'h4;
    #2;
    check("rst_wait", {31'b0, w_wait}, 32'h0);
    check("rst_rdata", w_rdata, 32'h0);
    check("rst_perr", {31'b0, w_perr}, 32'h0);
    t_rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // fixed latency read and byte-enable write
    preload(0, 1, 32'h24020010);
    transact(0, 1, 0, 32'h4, '0, '0, "fix_rd");
    preload(0, 2, 32'h0);
    transact(0, 0, 1, 32'h8, 32'hAABBCCDD, 4'b0101, "fix_be_wr");
    transact(0, 1, 0, 32'h8, '0, '0, "fix_be_rd");

    // misaligned read, then reset keeps memory
    transact(0, 1, 0, 32'h6, '0, '0, "fix_misal");
    do_reset();
    transact(0, 1, 0, 32'h4, '0, '0, "fix_retain");

    // request withdrawn while stalled
    sel = 0; t_addr = 32'h4; t_rd = 1'b1;
    @(posedge clk); #1;
    check("drop_inwait", {31'b0, w_wait}, 32'h1);
    t_rd = 1'b0;
    @(posedge clk); #1;
    m_perr[0] = 1'b1;
    check("drop_perr", {31'b0, w_perr}, 32'h1);
    transact(0, 1, 0, 32'h4, '0, '0, "drop_after");

    // zero-wait instance: range edges and read+write together
    do_reset();
    for (int w = 0; w < 16; w++) preload(1, w, $urandom);
    transact(1, 1, 0, 32'h1000, '0, '0, "z_first");
    transact(1, 1, 0, 32'h103C, '0, '0, "z_last");
    transact(1, 1, 1, 32'h1004, 32'hCAFEF00D, 4'hF, "z_rdwr");
    transact(1, 1, 0, 32'h1004, '0, '0, "z_rdwr_rb");
    do_reset();
    transact(1, 1, 0, 32'h1040, '0, '0, "z_past_end");
    do_reset();
    transact(1, 1, 0, 32'h0FFC, '0, '0, "z_below_base");
    transact(1, 0, 1, 32'h0FFC, 32'h12345678, 4'hF, "z_below_wr");

    // preload against a same-cycle bus write, same word then different words
    sel = 1; t_addr = 32'h1008; t_wr = 1'b1; t_wdata = 32'h11111111; t_be = 4'hF;
    t_load = 1'b1; t_laddr = 10'd2; t_ldata = 32'h22222222;
    @(posedge clk); #1;
    t_wr = 1'b0; t_load = 1'b0;
    m_mem[1][2] = 32'h22222222;
    transact(1, 1, 0, 32'h1008, '0, '0, "pl_same");
    sel = 1; t_addr = 32'h100C; t_wr = 1'b1; t_wdata = 32'h33333333; t_be = 4'hF;
    t_load = 1'b1; t_laddr = 10'd4; t_ldata = 32'h44444444;
    @(posedge clk); #1;
    t_wr = 1'b0; t_load = 1'b0;
    m_mem[1][3] = 32'h33333333;
    m_mem[1][4] = 32'h44444444;
    transact(1, 1, 0, 32'h100C, '0, '0, "pl_diff_bus");
    transact(1, 1, 0, 32'h1010, '0, '0, "pl_diff_load");

    for (int i = 0; i < 20; i++) begin
      int unsigned w;
      int unsigned op;
      w  = $urandom_range(0, 17);
      op = $urandom_range(0, 1);
      transact(1, op == 0, op == 1, 32'h1000 + 32'(w * 4), $urandom, 4'($urandom_range(0, 15)), "z_mix");
    end

    // random wait mode: two identical runs from the same seed
    do_reset();
    for (int w = 0; w < 16; w++) preload(2, w, $urandom);
    for (int i = 0; i < 50; i++) addrs[i] = $urandom_range(0, 15);
    for (int i = 0; i < 50; i++) transact(2, 1, 0, 32'(addrs[i] * 4), '0, '0, "rnd_a");
    do_reset();
    for (int i = 0; i < 50; i++) transact(2, 1, 0, 32'(addrs[i] * 4), '0, '0, "rnd_b");

    // fixed-latency random read/write mix with random byte enables
    do_reset();
    for (int w = 0; w < 8; w++) preload(0, w, $urandom);
    for (int i = 0; i < 30; i++) begin
      int unsigned w;
      int unsigned op;
      w  = $urandom_range(0, 7);
      op = $urandom_range(0, 1);
      transact(0, op == 0, op == 1, 32'(w * 4), $urandom, 4'($urandom_range(0, 15)), "fix_mix");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
